// File: rtl/bram_responder.sv
// -----------------------------------------------------------------------------
// bram_responder
//   Dual-port BRAM model sitting on the memory side of a kernel BRAM interface.
//   Two kernel ports (ce/we/address/dout in, din out) are serviced while the
//   block is IDLE. A host command port preloads (LOAD) or reads back (DUMP) a
//   run of words, wrapping at DEPTH.
//
//   Optional build macro: BRAM_RESPONDER_STATS_EN adds saturating 32-bit
//   rd_count / wr_count outputs counting kernel reads/writes issued in IDLE.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   ce0/1, we0/1          kernel port enable / write enable (we qualified by ce)
//   address0/1            kernel word address (index = address mod 2^clog2(DEPTH))
//   dout0/1               kernel write data
//   din0/1                kernel read data, READ_LATENCY cycles after the read
//   cmd_valid/cmd_ready   host command handshake (cmd_op 0=LOAD, 1=DUMP)
//   cmd_base, cmd_len     first word address, number of words
//   wr_valid/wr_ready     LOAD data stream, wr_data
//   rd_valid/rd_ready     DUMP data stream, rd_data
//   busy, done            busy in LOAD/DUMP; done pulses when a command ends
//   oob_err, coll_err     sticky out-of-range access / same-index dual write
//   dbg_state             current FSM state encoding
//   rd_count, wr_count    (BRAM_RESPONDER_STATS_EN only) kernel access counters
//
// Handshakes: every valid/ready pair transfers exactly on a cycle where both
// are high at the rising edge; valid never depends on ready, and once
// rd_valid is raised rd_data stays stable until rd_ready accepts it.
// -----------------------------------------------------------------------------
module bram_responder #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce0,
    input  logic                  we0,
    input  logic [ADDR_WIDTH-1:0] address0,
    input  logic [DATA_WIDTH-1:0] dout0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic                  ce1,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] address1,
    input  logic [DATA_WIDTH-1:0] dout1,
    output logic [DATA_WIDTH-1:0] din1,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_op,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  oob_err,
    output logic                  coll_err,
    output logic [2:0]            dbg_state
`ifdef BRAM_RESPONDER_STATS_EN
    ,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count
`endif
);

    localparam int                    IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);
    localparam logic [IW-1:0]         LAST_IDX = IW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD       = 3'd1,
        S_DUMP_ISSUE = 3'd2,
        S_DUMP_WAIT  = 3'd3,
        S_DUMP_VALID = 3'd4,
        S_ZERO       = 3'd5   // zero-length command: one cycle to pulse done
    } state_t;

    state_t                state, state_nxt;
    logic [IW-1:0]         ptr, ptr_nxt, ptr_inc;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic [2:0]            wait_cnt, wait_nxt;
    logic                  load_we, dump_issue;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic [DATA_WIDTH-1:0] mem   [DEPTH];
    logic [DATA_WIDTH-1:0] pipe0 [READ_LATENCY];
    logic [DATA_WIDTH-1:0] pipe1 [READ_LATENCY];

    // Kernel port decode; the ports only act while IDLE.
    logic          idle, in_rng0, in_rng1;
    logic [IW-1:0] idx0, idx1;
    logic          rd0, rd1, kwr0, kwr1, wr0, wr1, coll_hit, oob_hit;

    assign idle     = (state == S_IDLE);
    assign in_rng0  = (address0 < DEPTH_A);
    assign in_rng1  = (address1 < DEPTH_A);
    assign idx0     = address0[IW-1:0];
    assign idx1     = address1[IW-1:0];
    assign rd0      = idle & ce0 & ~we0;
    assign rd1      = idle & ce1 & ~we1;
    assign kwr0     = idle & ce0 & we0;
    assign kwr1     = idle & ce1 & we1;
    assign wr0      = kwr0 & in_rng0;
    assign wr1      = kwr1 & in_rng1;
    assign coll_hit = wr0 & wr1 & (idx0 == idx1);
    assign oob_hit  = idle & ((ce0 & ~in_rng0) | (ce1 & ~in_rng1));

    assign ptr_inc   = (ptr == LAST_IDX) ? '0 : ptr + 1'b1;
    assign din0      = idle ? pipe0[READ_LATENCY-1] : '0;
    assign din1      = idle ? pipe1[READ_LATENCY-1] : '0;
    assign rd_data   = rd_data_q;
    assign dbg_state = state;

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        cnt_nxt    = cnt;
        wait_nxt   = wait_cnt;
        cmd_ready  = 1'b0;
        wr_ready   = 1'b0;
        rd_valid   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        load_we    = 1'b0;
        dump_issue = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    ptr_nxt = IW'(cmd_base % DEPTH_A);
                    cnt_nxt = cmd_len;
                    if (cmd_len == '0) state_nxt = S_ZERO;
                    else if (cmd_op)   state_nxt = S_DUMP_ISSUE;
                    else               state_nxt = S_LOAD;
                end
            end
            S_ZERO: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            S_LOAD: begin
                busy     = 1'b1;
                wr_ready = (cnt != '0);
                if (wr_valid && wr_ready) begin
                    load_we = 1'b1;
                    ptr_nxt = ptr_inc;
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == ADDR_WIDTH'(1)) begin
                        done      = 1'b1;
                        state_nxt = S_IDLE;
                    end
                end
            end
            S_DUMP_ISSUE: begin
                busy       = 1'b1;
                dump_issue = 1'b1;
                wait_nxt   = 3'(READ_LATENCY - 1);
                state_nxt  = (READ_LATENCY == 1) ? S_DUMP_VALID : S_DUMP_WAIT;
            end
            S_DUMP_WAIT: begin
                // wait_cnt counts remaining cycles before rd_valid rises
                busy     = 1'b1;
                wait_nxt = wait_cnt - 1'b1;
                if (wait_cnt == 3'd1) state_nxt = S_DUMP_VALID;
            end
            S_DUMP_VALID: begin
                busy     = 1'b1;
                rd_valid = 1'b1;
                if (rd_ready) begin
                    ptr_nxt = ptr_inc;
                    cnt_nxt = cnt - 1'b1;
                    if (cnt == ADDR_WIDTH'(1)) begin
                        done      = 1'b1;
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_DUMP_ISSUE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            cnt       <= '0;
            wait_cnt  <= '0;
            rd_data_q <= '0;
            oob_err   <= 1'b0;
            coll_err  <= 1'b0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe0[i] <= '0;
                pipe1[i] <= '0;
            end
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            cnt      <= cnt_nxt;
            wait_cnt <= wait_nxt;
            if (dump_issue) rd_data_q <= mem[ptr];
            // Sampling mem here, alongside the write below, gives read-first.
            pipe0[0] <= (rd0 && in_rng0) ? mem[idx0] : '0;
            pipe1[0] <= (rd1 && in_rng1) ? mem[idx1] : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe0[i] <= pipe0[i-1];
                pipe1[i] <= pipe1[i-1];
            end
            if (oob_hit)  oob_err  <= 1'b1;
            if (coll_hit) coll_err <= 1'b1;
        end
    end

    // Storage is not reset. Port 1 is written last so it wins a collision.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (load_we) mem[ptr]  <= wr_data;
            if (wr0)     mem[idx0] <= dout0;
            if (wr1)     mem[idx1] <= dout1;
        end
    end

`ifdef BRAM_RESPONDER_STATS_EN
    logic [32:0] rd_sum, wr_sum;
    always_comb begin
        rd_sum = {1'b0, rd_count} + 33'(rd0) + 33'(rd1);
        wr_sum = {1'b0, wr_count} + 33'(kwr0) + 33'(kwr1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            rd_count <= rd_sum[32] ? '1 : rd_sum[31:0];
            wr_count <= wr_sum[32] ? '1 : wr_sum[31:0];
        end
    end
`endif

endmodule

// File: tb/tb_bram_responder.sv
module tb_bram_responder;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int D  = 1024;
  localparam int L  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          ce0, we0, ce1, we1;
  logic [AW-1:0] address0, address1;
  logic [DW-1:0] dout0, dout1, din0, din1;
  logic          cmd_valid, cmd_ready, cmd_op;
  logic [AW-1:0] cmd_base, cmd_len;
  logic          wr_valid, wr_ready, rd_valid, rd_ready;
  logic [DW-1:0] wr_data, rd_data;
  logic          busy, done, oob_err, coll_err;
  logic [2:0]    dbg_state;
`ifdef BRAM_RESPONDER_STATS_EN
  logic [31:0]   rd_count, wr_count;
`endif

  bram_responder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(D), .READ_LATENCY(L)) dut (
    .clk(clk), .rst(rst),
    .ce0(ce0), .we0(we0), .address0(address0), .dout0(dout0), .din0(din0),
    .ce1(ce1), .we1(we1), .address1(address1), .dout1(dout1), .din1(din1),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done), .oob_err(oob_err), .coll_err(coll_err),
    .dbg_state(dbg_state)
`ifdef BRAM_RESPONDER_STATS_EN
    , .rd_count(rd_count), .wr_count(wr_count)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  logic [DW-1:0] ref_mem [D];
  logic [DW-1:0] k0_q[$], k1_q[$];   // expected din per port, oldest first
  logic [DW-1:0] load_q[$];          // data for the next LOAD
  logic [DW-1:0] exp_q[$];           // expected DUMP words
  logic          exp_oob, exp_coll;
  logic [31:0]   exp_rd, exp_wr;

  task automatic clear_inputs();
    ce0 = 0; we0 = 0; ce1 = 0; we1 = 0;
    address0 = '0; address1 = '0; dout0 = '0; dout1 = '0;
    cmd_valid = 0; cmd_op = 0; cmd_base = '0; cmd_len = '0;
    wr_valid = 0; wr_data = '0; rd_ready = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    exp_oob = 0; exp_coll = 0; exp_rd = 0; exp_wr = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic kernel_begin();
    k0_q = {}; k1_q = {};
    for (int i = 0; i < L; i++) begin
      k0_q.push_back('0);
      k1_q.push_back('0);
    end
  endtask

  task automatic kernel_step(input logic c0, input logic w0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                             input logic c1, input logic w1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    logic [DW-1:0] e0, e1, r0, r1;
    ce0 = c0; we0 = w0; address0 = a0; dout0 = d0;
    ce1 = c1; we1 = w1; address1 = a1; dout1 = d1;
    @(negedge clk);
    e0 = k0_q.pop_front();
    e1 = k1_q.pop_front();
    total++; if (din0 !== e0) begin bad++; $display("FAIL din0 got=%h exp=%h t=%0t", din0, e0, $time); end
    total++; if (din1 !== e1) begin bad++; $display("FAIL din1 got=%h exp=%h t=%0t", din1, e1, $time); end
    total++; if (oob_err !== exp_oob) begin bad++; $display("FAIL oob_err got=%b exp=%b t=%0t", oob_err, exp_oob, $time); end
    total++; if (coll_err !== exp_coll) begin bad++; $display("FAIL coll_err got=%b exp=%b t=%0t", coll_err, exp_coll, $time); end
`ifdef BRAM_RESPONDER_STATS_EN
    total++; if (rd_count !== exp_rd) begin bad++; $display("FAIL rd_count got=%0d exp=%0d", rd_count, exp_rd); end
    total++; if (wr_count !== exp_wr) begin bad++; $display("FAIL wr_count got=%0d exp=%0d", wr_count, exp_wr); end
`endif
    // reads see the memory before this cycle's writes
    r0 = (c0 && !w0 && a0 < D) ? ref_mem[a0[9:0]] : '0;
    r1 = (c1 && !w1 && a1 < D) ? ref_mem[a1[9:0]] : '0;
    k0_q.push_back(r0);
    k1_q.push_back(r1);
    if (c0 && w0 && a0 < D) ref_mem[a0[9:0]] = d0;
    if (c1 && w1 && a1 < D) ref_mem[a1[9:0]] = d1;
    if (c0 && w0 && c1 && w1 && a0 < D && a1 < D && a0 == a1) exp_coll = 1;
    if ((c0 && a0 >= D) || (c1 && a1 >= D)) exp_oob = 1;
    if (c0 && !w0 && exp_rd != 32'hFFFF_FFFF) exp_rd++;
    if (c1 && !w1 && exp_rd != 32'hFFFF_FFFF) exp_rd++;
    if (c0 && w0 && exp_wr != 32'hFFFF_FFFF) exp_wr++;
    if (c1 && w1 && exp_wr != 32'hFFFF_FFFF) exp_wr++;
    @(posedge clk); #1;
  endtask

  task automatic kernel_flush();
    for (int i = 0; i < L; i++) kernel_step(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic host_load(input int base, input int len);
    int i = 0;
    int cyc = 0;
    logic hs;
    cmd_valid = 1; cmd_op = 0; cmd_base = AW'(base); cmd_len = AW'(len);
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL load_cmd_ready got=%b exp=1", cmd_ready); end
    @(posedge clk); #1;
    while (i < len) begin
      if (cyc > len * 8 + 50) begin
        bad++; total++; $display("FAIL load_timeout words=%0d exp=%0d", i, len);
        break;
      end
      wr_valid = ($urandom_range(0, 3) != 0);
      wr_data  = load_q[i];
      // host-side junk that must be ignored while busy
      cmd_valid = $urandom_range(0, 1); cmd_op = 1; cmd_len = AW'(3);
      ce1 = 1; we1 = 1; address1 = AW'($urandom_range(0, D - 1)); dout1 = $urandom;
      @(negedge clk);
      hs = wr_valid && wr_ready;
      total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL load_wr_ready got=%b exp=1", wr_ready); end
      total++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin bad++; $display("FAIL load_busy busy=%b cmd_ready=%b exp=1/0", busy, cmd_ready); end
      total++; if (done !== (hs && i == len - 1)) begin bad++; $display("FAIL load_done got=%b exp=%b word=%0d", done, hs && i == len - 1, i); end
      if (hs) begin
        ref_mem[(base + i) % D] = wr_data;
        i++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    clear_inputs();
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL load_end busy=%b done=%b exp=0/0", busy, done); end
    @(posedge clk); #1;
  endtask

  task automatic host_dump(input int base, input int len);
    int cyc = 0;
    int exp_cyc = L;
    logic started = 0;
    logic prev_hold = 0;
    logic [DW-1:0] prev_data = '0;
    exp_q = {};
    for (int i = 0; i < len; i++) exp_q.push_back(ref_mem[(base + i) % D]);
    cmd_valid = 1; cmd_op = 1; cmd_base = AW'(base); cmd_len = AW'(len);
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL dump_cmd_ready got=%b exp=1", cmd_ready); end
    @(posedge clk); #1;
    while (exp_q.size() > 0) begin
      if (cyc > len * (L + 1) * 4 + 50) begin
        bad++; total++; $display("FAIL dump_timeout left=%0d exp=0", exp_q.size());
        break;
      end
      rd_ready = $urandom_range(0, 1);
      cmd_valid = $urandom_range(0, 1); cmd_op = 0; cmd_len = AW'(2);
      ce0 = 1; we0 = 0; address0 = AW'($urandom_range(0, D - 1));
      @(negedge clk);
      total++; if (din0 !== '0) begin bad++; $display("FAIL dump_din0 got=%h exp=0", din0); end
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL dump_cmd_ready_busy got=%b exp=0", cmd_ready); end
      if (rd_valid) begin
        if (!started) begin
          total++; if (cyc != exp_cyc) begin bad++; $display("FAIL dump_latency got=%0d exp=%0d", cyc, exp_cyc); end
          started = 1;
        end
        total++; if (rd_data !== exp_q[0]) begin bad++; $display("FAIL dump_data got=%h exp=%h", rd_data, exp_q[0]); end
        if (prev_hold) begin
          total++; if (rd_data !== prev_data) begin bad++; $display("FAIL dump_hold got=%h exp=%h", rd_data, prev_data); end
        end
        total++; if (done !== (rd_ready && exp_q.size() == 1)) begin bad++; $display("FAIL dump_done got=%b exp=%b", done, rd_ready && exp_q.size() == 1); end
        if (rd_ready) begin
          void'(exp_q.pop_front());
          started = 0;
          exp_cyc = cyc + L + 1;
        end
      end else begin
        total++; if (done !== 1'b0) begin bad++; $display("FAIL dump_done_idle got=%b exp=0", done); end
      end
      prev_hold = rd_valid && !rd_ready;
      prev_data = rd_data;
      @(posedge clk); #1;
      cyc++;
    end
    clear_inputs();
    @(negedge clk);
    total++; if (busy !== 1'b0 || rd_valid !== 1'b0) begin bad++; $display("FAIL dump_end busy=%b rd_valid=%b exp=0/0", busy, rd_valid); end
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    exp_oob = 0; exp_coll = 0; exp_rd = 0; exp_wr = 0;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    total++; if ({busy, done, wr_ready, rd_valid, oob_err, coll_err} !== 6'b0) begin
      bad++; $display("FAIL reset_flags got=%b exp=000000", {busy, done, wr_ready, rd_valid, oob_err, coll_err}); end
    total++; if (din0 !== '0 || din1 !== '0 || rd_data !== '0) begin
      bad++; $display("FAIL reset_data din0=%h din1=%h rd_data=%h exp=0", din0, din1, rd_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_preload();
    load_q = {};
    for (int i = 0; i < D; i++) load_q.push_back($urandom);
    host_load(0, D);
  endtask

  task automatic test_load_read();
    load_q = '{32'd11, 32'd22, 32'd33, 32'd44};
    host_load(0, 4);
    kernel_begin();
    kernel_step(1, 0, 32'd2, '0, 1, 0, 32'd3, '0);
    kernel_step(1, 0, 32'd0, '0, 0, 0, '0, '0);
    kernel_flush();
  endtask

  task automatic test_read_first();
    kernel_begin();
    kernel_step(1, 0, 32'd5, '0, 1, 1, 32'd5, 32'hAB);
    kernel_step(1, 0, 32'd5, '0, 0, 0, '0, '0);
    kernel_flush();
  endtask

  task automatic test_random_kernel();
    logic c0, w0, c1, w1;
    logic [AW-1:0] a0, a1;
    kernel_begin();
    repeat (300) begin
      c0 = $urandom_range(0, 1); w0 = $urandom_range(0, 1);
      c1 = $urandom_range(0, 1); w1 = $urandom_range(0, 1);
      a0 = AW'($urandom_range(0, 31));
      a1 = AW'($urandom_range(0, 31));
      if (w0 && w1 && a0 == a1) a1 = AW'((a1 + 1) % 32);   // keep coll_err clear here
      kernel_step(c0, w0, a0, $urandom, c1, w1, a1, $urandom);
    end
    kernel_flush();
  endtask

  task automatic test_collision();
    kernel_begin();
    kernel_step(1, 1, 32'd7, 32'd1, 1, 1, 32'd7, 32'd2);
    kernel_step(1, 0, 32'd7, '0, 1, 0, 32'd7, '0);
    repeat (4) kernel_step(0, 0, '0, '0, 0, 0, '0, '0);
    kernel_flush();
    total++; if (coll_err !== 1'b1) begin bad++; $display("FAIL coll_sticky got=%b exp=1", coll_err); end
    do_reset();
    @(negedge clk);
    total++; if (coll_err !== 1'b0) begin bad++; $display("FAIL coll_cleared got=%b exp=0", coll_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_dump_wrap();
    host_dump(D - 2, 4);
  endtask

  task automatic test_abort();
    do_reset();
    cmd_valid = 1; cmd_op = 0; cmd_base = AW'(8); cmd_len = AW'(8);
    @(posedge clk); #1;
    cmd_valid = 0;
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1; wr_data = $urandom;
      @(negedge clk);
      total++; if (done !== 1'b0 || wr_ready !== 1'b1) begin bad++; $display("FAIL abort_word done=%b wr_ready=%b exp=0/1", done, wr_ready); end
      ref_mem[8 + i] = wr_data;
      @(posedge clk); #1;
    end
    wr_valid = 0;
    rst = 1;
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b exp=0", done); end
    @(posedge clk); #1;
    rst = 0;
    exp_oob = 0; exp_coll = 0; exp_rd = 0; exp_wr = 0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++; $display("FAIL abort_idle busy=%b done=%b cmd_ready=%b exp=0/0/1", busy, done, cmd_ready); end
    @(posedge clk); #1;
    kernel_begin();
    kernel_step(1, 0, 32'd8, '0, 1, 0, 32'd9, '0);
    kernel_step(1, 0, 32'd10, '0, 1, 0, 32'd11, '0);
    kernel_step(1, 0, 32'd9000, '0, 0, 0, '0, '0);
    kernel_step(0, 0, '0, '0, 1, 1, 32'd9000, 32'hDEAD_BEEF);   // dropped; aliases index 808
    kernel_step(1, 0, 32'd808, '0, 0, 0, '0, '0);
    kernel_flush();
  endtask

  task automatic test_zero_len();
    do_reset();
    cmd_valid = 1; cmd_op = $urandom_range(0, 1); cmd_base = AW'(5); cmd_len = '0;
    @(negedge clk);
    total++; if (done !== 1'b0) begin bad++; $display("FAIL zero_accept_done got=%b exp=0", done); end
    @(posedge clk); #1;
    cmd_valid = 0;
    @(negedge clk);
    total++; if (done !== 1'b1 || cmd_ready !== 1'b0) begin bad++; $display("FAIL zero_done done=%b cmd_ready=%b exp=1/0", done, cmd_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (done !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL zero_after done=%b cmd_ready=%b exp=0/1", done, cmd_ready); end
    @(posedge clk); #1;
    kernel_begin();
    kernel_step(1, 0, 32'd1, '0, 0, 0, '0, '0);
    kernel_step(1, 0, 32'd2, '0, 1, 1, 32'd3, 32'h33);
    kernel_step(0, 0, '0, '0, 1, 0, 32'd4, '0);
    kernel_step(1, 1, 32'd5, 32'h55, 0, 0, '0, '0);
    kernel_flush();
`ifdef BRAM_RESPONDER_STATS_EN
    total++; if (rd_count !== 32'd3) begin bad++; $display("FAIL stats_rd got=%0d exp=3", rd_count); end
    total++; if (wr_count !== 32'd2) begin bad++; $display("FAIL stats_wr got=%0d exp=2", wr_count); end
`endif
  endtask

  task automatic test_back_to_back();
    int base, len;
    repeat (8) begin
      base = $urandom_range(0, D - 1);
      len  = $urandom_range(1, 20);
      if ($urandom_range(0, 1) == 0) begin
        load_q = {};
        for (int i = 0; i < len; i++) load_q.push_back($urandom);
        host_load(base, len);
      end else begin
        host_dump(base, len);
      end
    end
    host_dump(D - 3, 6);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_preload();
    test_load_read();
    test_read_first();
    test_random_kernel();
    test_collision();
    test_dump_wrap();
    test_abort();
    test_zero_len();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
